// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the PISO serializer slice.
package serializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY
  } state_t;

  localparam int unsigned DATA_W = 8;

  // Width of a counter that indexes 0..width-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Modulo-WIDTH up-counter with synchronous clear, enable and terminal-count flag.
module bit_counter
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  output logic [cnt_w(WIDTH)-1:0]   cnt,
  output logic                      last
);

  localparam int unsigned CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] TC = CW'(WIDTH - 1);

  // Count bit positions; clear wins over enable, wrap after the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

  // Terminal count marks the final data bit of a frame.
  assign last = (cnt == TC);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with load handshake and back-to-back frames.
// Optional even-parity trailer bit enabled by defining PISO_SERIALIZER_PARITY_EN.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DATA_W,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PI,
  input  logic             load,
  output logic             ready,
  output logic             SO,
  output logic             sValid,
  output logic             done
);

  localparam int unsigned CW = cnt_w(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             frame_end;
  logic             accept;
  logic             out_bit;
  logic             unused_cnt;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par;
`endif

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state == S_SHIFT),
    .cnt  (cnt),
    .last (last_bit)
  );

  // The top only needs the terminal flag; the raw count stays inside the counter.
  assign unused_cnt = ^cnt;

`ifdef PISO_SERIALIZER_PARITY_EN
  assign frame_end = (state == S_PARITY);
`else
  assign frame_end = (state == S_SHIFT) && last_bit;
`endif

  assign ready  = (state == S_IDLE) || frame_end;
  assign done   = frame_end;
  assign accept = load && ready;
  assign sValid = (state != S_IDLE);

  // Shift toward the output end with zero fill; select the output-end bit.
  always_comb begin
    if (LSB_FIRST != 0) begin
      shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
      out_bit   = shreg[0];
    end else begin
      shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
      out_bit   = shreg[WIDTH-1];
    end
  end

  // Serial output is forced low whenever no valid bit is being sent.
  always_comb begin
    SO = 1'b0;
    if (state == S_SHIFT) begin
      SO = out_bit;
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    else if (state == S_PARITY) begin
      SO = par;
    end
`endif
  end

  // Frame FSM: capture on accepted load (also in the final-bit cycle), shift, optional parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      shreg <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (accept) begin
      state <= S_SHIFT;
      shreg <= PI;
`ifdef PISO_SERIALIZER_PARITY_EN
      par   <= ^PI;
`endif
    end else begin
      case (state)
        S_IDLE: state <= S_IDLE;
        S_SHIFT: begin
          shreg <= shreg_nxt;
          if (last_bit) begin
`ifdef PISO_SERIALIZER_PARITY_EN
            state <= S_PARITY;
`else
            state <= S_IDLE;
`endif
          end
        end
        S_PARITY: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: an MSB-first and an LSB-first instance
// share stimulus; per-instance scoreboards hold the expected serial bit stream.
// Honours PISO_SERIALIZER_PARITY_EN (frame length and done position follow it).
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FLEN = PAR_EN ? 9 : 8;

  typedef struct {
    logic [7:0] pi;
    logic [7:0] seq_m;  // MSB-first stream, first bit in [7]
    logic [7:0] seq_l;  // LSB-first stream, first bit in [7]
    logic       par;
  } vec_t;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] PI = '0;
  logic       load = 1'b0;
  logic       rdy_m, so_m, sv_m, done_m;
  logic       rdy_l, so_l, sv_l, done_l;
  logic       mon_en = 1'b0;

  int nchk = 0;
  int nfail = 0;

  exp_t qm[$];
  exp_t ql[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst(rst), .PI(PI), .load(load),
    .ready(rdy_m), .SO(so_m), .sValid(sv_m), .done(done_m)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1)) dut_l (
    .clk(clk), .rst(rst), .PI(PI), .load(load),
    .ready(rdy_l), .SO(so_l), .sValid(sv_l), .done(done_l)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] pi, input logic [7:0] sm,
                              input logic [7:0] sl, input logic p);
    vec_t v;
    v.pi = pi; v.seq_m = sm; v.seq_l = sl; v.par = p;
    return v;
  endfunction

  task automatic push_frame(input vec_t v);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.last = !PAR_EN && (i == 7);
      e.b = v.seq_m[7-i]; qm.push_back(e);
      e.b = v.seq_l[7-i]; ql.push_back(e);
    end
    if (PAR_EN) begin
      e.last = 1'b1;
      e.b = v.par;
      qm.push_back(e);
      ql.push_back(e);
    end
  endtask

  // Drive a load that is expected to be accepted at the next rising edge.
  task automatic send(input vec_t v);
    #1;
    PI = v.pi;
    load = 1'b1;
    @(posedge clk);
    push_frame(v);
    #1;
    load = 1'b0;
    PI = 8'($urandom);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_so_m", so_m, 0);   chk("rst_sv_m", sv_m, 0);
    chk("rst_done_m", done_m, 0); chk("rst_rdy_m", rdy_m, 1);
    chk("rst_so_l", so_l, 0);   chk("rst_sv_l", sv_l, 0);
    chk("rst_done_l", done_l, 0); chk("rst_rdy_l", rdy_l, 1);
  endtask

  // MSB-first monitor
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (sv_m) begin
        if (qm.size() == 0) begin
          chk("m_unexpected_valid", 1, 0);
        end else begin
          e = qm.pop_front();
          chk("m_so", so_m, e.b);
          chk("m_done", done_m, e.last);
          chk("m_ready", rdy_m, e.last);
        end
      end else begin
        chk("m_missing_bits", qm.size(), 0);
        chk("m_idle_so", so_m, 0);
        chk("m_idle_done", done_m, 0);
        chk("m_idle_ready", rdy_m, 1);
      end
    end
  end

  // LSB-first monitor
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (sv_l) begin
        if (ql.size() == 0) begin
          chk("l_unexpected_valid", 1, 0);
        end else begin
          e = ql.pop_front();
          chk("l_so", so_l, e.b);
          chk("l_done", done_l, e.last);
          chk("l_ready", rdy_l, e.last);
        end
      end else begin
        chk("l_missing_bits", ql.size(), 0);
        chk("l_idle_so", so_l, 0);
        chk("l_idle_done", done_l, 0);
        chk("l_idle_ready", rdy_l, 1);
      end
    end
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = mk(8'hB2, 8'hB2, 8'h4D, 1'b0);
    tbl[1] = mk(8'h07, 8'h07, 8'hE0, 1'b1);
    tbl[2] = mk(8'h01, 8'h01, 8'h80, 1'b1);
    tbl[3] = mk(8'h80, 8'h80, 8'h01, 1'b1);
    tbl[4] = mk(8'hFF, 8'hFF, 8'hFF, 1'b0);
    tbl[5] = mk(8'h00, 8'h00, 8'h00, 1'b0);

    // Reset state
    #1;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    // Single frames from the table
    for (int i = 0; i < 6; i++) begin
      send(tbl[i]);
      repeat (FLEN + 2) @(posedge clk);
    end

    // Back-to-back: second load lands in the final-bit cycle of the first frame
    send(mk(8'hA5, 8'hA5, 8'hA5, 1'b0));
    repeat (FLEN - 1) @(posedge clk);
    send(mk(8'h3C, 8'h3C, 8'h3C, 1'b0));
    repeat (FLEN + 2) @(posedge clk);

    // Load while busy is ignored
    send(mk(8'h0F, 8'h0F, 8'hF0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    PI = 8'hFF;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    PI = 8'h55;
    repeat (FLEN + 2) @(posedge clk);

    // Reset mid-frame after three bits, then a fresh frame
    send(mk(8'h01, 8'h01, 8'h80, 1'b1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    qm.delete();
    ql.delete();
    @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    send(mk(8'h80, 8'h80, 8'h01, 1'b1));
    repeat (FLEN + 3) @(posedge clk);

    @(negedge clk);
    #1;
    chk("m_queue_drained", qm.size(), 0);
    chk("l_queue_drained", ql.size(), 0);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
